// File: rtl/sample_mul_share_arb_if.sv
// Request/response bundle between HLS compute loops and the shared multiplier sequencer.
// master = requester/consumer side, slave = sample_mul_share_arb.
interface sample_mul_share_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din1;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_dout;
  logic                          busy;

  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout, busy
  );

  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout, busy
  );
endinterface

// File: rtl/sample_mul_share_arb.sv
// Round-robin arbiter time-sharing one signed truncating multiplier among NUM_REQ
// requesters, with a MUL_LATENCY-deep globally stalled result pipeline.
module sample_mul_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 11,
  parameter int MUL_LATENCY = 1,
  parameter int ID_WIDTH    = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  sample_mul_share_arb_if.slave  bus
);

  localparam int LAST = MUL_LATENCY - 1;

  logic [MUL_LATENCY-1:0] stage_valid_r;
  logic [ID_WIDTH-1:0]    stage_id_r   [MUL_LATENCY];
  logic [DATA_WIDTH-1:0]  stage_data_r [MUL_LATENCY];
  logic [ID_WIDTH-1:0]    ptr_r;

  logic                   advance_s;
  logic                   grant_found_s;
  logic [ID_WIDTH-1:0]    grant_s;
  logic [ID_WIDTH-1:0]    ptr_next_s;
  logic [NUM_REQ-1:0]     ready_s;
  logic                   accept_s;
  logic [DATA_WIDTH-1:0]  product_s;

  function automatic int rr_index(input logic [ID_WIDTH-1:0] p, input int k);
    int idx;
    idx = int'(p) + k;
    if (idx >= NUM_REQ) begin
      idx = idx - NUM_REQ;
    end else begin
      idx = idx;
    end
    return idx;
  endfunction

  // Full-width signed product, then keep the low DATA_WIDTH bits (wraps, never saturates).
  function automatic logic [DATA_WIDTH-1:0] mul_trunc(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] full;
    full = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
           $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    return full[DATA_WIDTH-1:0];
  endfunction

  // Round-robin search: scanning from the far end lets the nearest valid index to ptr win.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_index(ptr_r, k)]) begin
        grant_found_s = 1'b1;
        grant_s       = ID_WIDTH'(rr_index(ptr_r, k));
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Handshake, pointer update and operand selection for the granted requester.
  always_comb begin
    advance_s = !stage_valid_r[LAST] || bus.rsp_ready;
    ready_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = advance_s && grant_found_s && (grant_s == ID_WIDTH'(i)) && !ap_rst;
    end
    accept_s  = |(bus.req_valid & ready_s);
    if (grant_s == ID_WIDTH'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_s + ID_WIDTH'(1);
    end
    product_s = mul_trunc(bus.req_din0[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH],
                          bus.req_din1[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Result pipeline and arbitration pointer; a stall freezes every stage including bubbles.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stage_valid_r <= '0;
      ptr_r         <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        stage_id_r[s]   <= '0;
        stage_data_r[s] <= '0;
      end
    end else if (advance_s) begin
      stage_valid_r[0] <= accept_s;
      if (accept_s) begin
        stage_id_r[0]   <= grant_s;
        stage_data_r[0] <= product_s;
        ptr_r           <= ptr_next_s;
      end
      for (int s = 1; s < MUL_LATENCY; s++) begin
        stage_valid_r[s] <= stage_valid_r[s-1];
        stage_id_r[s]    <= stage_id_r[s-1];
        stage_data_r[s]  <= stage_data_r[s-1];
      end
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = stage_valid_r[LAST];
  assign bus.rsp_id    = stage_id_r[LAST];
  assign bus.rsp_dout  = stage_data_r[LAST];
  assign bus.busy      = (|stage_valid_r) || (|bus.req_valid);

endmodule

// File: tb/tb_sample_mul_share_arb.sv
// Directed bench: instance a has MUL_LATENCY=1, instance b has MUL_LATENCY=2.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_sample_mul_share_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sample_mul_share_arb_if #(.NUM_REQ(4), .DATA_WIDTH(11), .ID_WIDTH(2)) ia ();
  sample_mul_share_arb_if #(.NUM_REQ(4), .DATA_WIDTH(11), .ID_WIDTH(2)) ib ();

  sample_mul_share_arb #(.NUM_REQ(4), .DATA_WIDTH(11), .MUL_LATENCY(1), .ID_WIDTH(2)) dut_a (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (ia)
  );

  sample_mul_share_arb #(.NUM_REQ(4), .DATA_WIDTH(11), .MUL_LATENCY(2), .ID_WIDTH(2)) dut_b (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (ib)
  );

  task automatic set_ops_a(input int i, input int x, input int y);
    ia.req_din0[i*11 +: 11] = 11'(x);
    ia.req_din1[i*11 +: 11] = 11'(y);
  endtask

  task automatic set_ops_b(input int i, input int x, input int y);
    ib.req_din0[i*11 +: 11] = 11'(x);
    ib.req_din1[i*11 +: 11] = 11'(y);
  endtask

  task automatic test_reset();
    @(negedge clk);
    ia.req_valid = 4'b1111;
    ib.req_valid = 4'b1111;
    #1;
    checks++; if (ia.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_a got %b exp %b", ia.req_ready, 4'b0000); end
    checks++; if (ib.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_b got %b exp %b", ib.req_ready, 4'b0000); end
    checks++; if (ia.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %b exp %b", ia.rsp_valid, 1'b0); end
    checks++; if (ib.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %b exp %b", ib.rsp_valid, 1'b0); end
    checks++; if (ia.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id_a got %0d exp %0d", ia.rsp_id, 2'd0); end
    checks++; if (ia.rsp_dout !== 11'h000) begin errors++; $display("FAIL reset_dout_a got %h exp %h", ia.rsp_dout, 11'h000); end
    ia.req_valid = 4'b0000;
    ib.req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a got %b exp %b", ia.busy, 1'b0); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_ops_a(0, 5, -3);
    ia.req_valid = 4'b0001;
    #1;
    checks++; if (ia.req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b exp %b", ia.req_ready, 4'b0001); end
    checks++; if (ia.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp %b", ia.busy, 1'b1); end
    @(negedge clk);
    ia.req_valid = 4'b0000;
    #1;
    checks++; if (ia.rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp %b", ia.rsp_valid, 1'b1); end
    checks++; if (ia.rsp_id !== 2'd0) begin errors++; $display("FAIL basic_id got %0d exp %0d", ia.rsp_id, 2'd0); end
    checks++; if (ia.rsp_dout !== 11'h7F1) begin errors++; $display("FAIL basic_dout got %h exp %h", ia.rsp_dout, 11'h7F1); end
    @(negedge clk);
    #1;
    checks++; if (ia.rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp %b", ia.rsp_valid, 1'b0); end
  endtask

  task automatic test_truncation();
    // ptr is 1 here; only req2 asks.
    @(negedge clk);
    set_ops_a(2, 40, 40);
    ia.req_valid = 4'b0100;
    #1;
    checks++; if (ia.req_ready !== 4'b0100) begin errors++; $display("FAIL trunc_ready got %b exp %b", ia.req_ready, 4'b0100); end
    @(negedge clk);
    ia.req_valid = 4'b0000;
    #1;
    checks++; if (ia.rsp_id !== 2'd2) begin errors++; $display("FAIL trunc_id got %0d exp %0d", ia.rsp_id, 2'd2); end
    checks++; if (ia.rsp_dout !== 11'h640) begin errors++; $display("FAIL trunc_dout got %h exp %h", ia.rsp_dout, 11'h640); end
  endtask

  task automatic test_pointer_wrap();
    for (int i = 0; i < 4; i++) set_ops_a(i, i + 1, 3);
    // ptr=3: req1 alone is found after wrapping through 3 and 0, leaving ptr=2.
    @(negedge clk);
    ia.req_valid = 4'b0010;
    #1;
    checks++; if (ia.req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_pre_ready got %b exp %b", ia.req_ready, 4'b0010); end
    @(negedge clk);
    ia.req_valid = 4'b1001;
    #1;
    checks++; if (ia.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first_ready got %b exp %b", ia.req_ready, 4'b1000); end
    checks++; if (ia.rsp_dout !== 11'd6) begin errors++; $display("FAIL wrap_pre_dout got %0d exp %0d", ia.rsp_dout, 11'd6); end
    @(negedge clk);
    ia.req_valid = 4'b0001;
    #1;
    checks++; if (ia.req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second_ready got %b exp %b", ia.req_ready, 4'b0001); end
    checks++; if (ia.rsp_id !== 2'd3) begin errors++; $display("FAIL wrap_first_id got %0d exp %0d", ia.rsp_id, 2'd3); end
    checks++; if (ia.rsp_dout !== 11'd12) begin errors++; $display("FAIL wrap_first_dout got %0d exp %0d", ia.rsp_dout, 11'd12); end
    @(negedge clk);
    ia.req_valid = 4'b0000;
    #1;
    checks++; if (ia.rsp_id !== 2'd0) begin errors++; $display("FAIL wrap_second_id got %0d exp %0d", ia.rsp_id, 2'd0); end
    checks++; if (ia.rsp_dout !== 11'd3) begin errors++; $display("FAIL wrap_second_dout got %0d exp %0d", ia.rsp_dout, 11'd3); end
  endtask

  task automatic test_contention();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    // ptr=1: granting req3 brings ptr back to 0 before the full-contention run.
    @(negedge clk);
    ia.req_valid = 4'b1000;
    #1;
    checks++; if (ia.req_ready !== 4'b1000) begin errors++; $display("FAIL cont_pre_ready got %b exp %b", ia.req_ready, 4'b1000); end
    @(negedge clk);
    ia.req_valid = 4'b1111;
    #1;
    checks++; if (ia.req_ready !== 4'b0001) begin errors++; $display("FAIL cont_ready_0 got %b exp %b", ia.req_ready, 4'b0001); end
    checks++; if (ia.rsp_id !== 2'd3) begin errors++; $display("FAIL cont_pre_id got %0d exp %0d", ia.rsp_id, 2'd3); end
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      #1;
      checks++; if (ia.req_ready !== (4'b0001 << order[k])) begin errors++; $display("FAIL cont_ready_%0d got %b exp %b", k, ia.req_ready, 4'b0001 << order[k]); end
      checks++; if (ia.rsp_valid !== 1'b1) begin errors++; $display("FAIL cont_valid_%0d got %b exp %b", k, ia.rsp_valid, 1'b1); end
      checks++; if (ia.rsp_id !== 2'(order[k-1])) begin errors++; $display("FAIL cont_id_%0d got %0d exp %0d", k, ia.rsp_id, order[k-1]); end
      checks++; if (ia.rsp_dout !== 11'(3 * (order[k-1] + 1))) begin errors++; $display("FAIL cont_dout_%0d got %0d exp %0d", k, ia.rsp_dout, 3 * (order[k-1] + 1)); end
    end
    @(negedge clk);
    ia.req_valid = 4'b0000;
    #1;
    checks++; if (ia.rsp_id !== 2'd1) begin errors++; $display("FAIL cont_last_id got %0d exp %0d", ia.rsp_id, 2'd1); end
    checks++; if (ia.rsp_dout !== 11'd6) begin errors++; $display("FAIL cont_last_dout got %0d exp %0d", ia.rsp_dout, 11'd6); end
  endtask

  task automatic test_backpressure();
    int rr  [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int rv  [10] = '{15, 15, 15, 15, 15, 15, 15, 0, 0, 0};
    int erd [10] = '{1, 2, 0, 0, 0, 4, 8, 0, 0, 0};
    int evl [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int eid [10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    int edo [10] = '{0, 0, 5, 5, 5, 5, 10, 15, 20, 0};
    for (int i = 0; i < 4; i++) set_ops_b(i, i + 1, 5);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      ib.rsp_ready = rr[t][0];
      ib.req_valid = 4'(rv[t]);
      #1;
      checks++; if (ib.req_ready !== 4'(erd[t])) begin errors++; $display("FAIL bp_ready_t%0d got %b exp %b", t, ib.req_ready, 4'(erd[t])); end
      checks++; if (ib.rsp_valid !== evl[t][0]) begin errors++; $display("FAIL bp_valid_t%0d got %b exp %b", t, ib.rsp_valid, evl[t][0]); end
      if (evl[t] == 1) begin
        checks++; if (ib.rsp_id !== 2'(eid[t])) begin errors++; $display("FAIL bp_id_t%0d got %0d exp %0d", t, ib.rsp_id, eid[t]); end
        checks++; if (ib.rsp_dout !== 11'(edo[t])) begin errors++; $display("FAIL bp_dout_t%0d got %0d exp %0d", t, ib.rsp_dout, edo[t]); end
      end
    end
    checks++; if (ib.busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got %b exp %b", ib.busy, 1'b0); end
  endtask

  task automatic test_async_reset();
    set_ops_b(0, 3, 3);
    set_ops_b(2, 4, 4);
    @(negedge clk);
    ib.req_valid = 4'b0101;
    #1;
    checks++; if (ib.req_ready !== 4'b0001) begin errors++; $display("FAIL ar_ready0 got %b exp %b", ib.req_ready, 4'b0001); end
    @(negedge clk);
    #1;
    checks++; if (ib.req_ready !== 4'b0100) begin errors++; $display("FAIL ar_ready2 got %b exp %b", ib.req_ready, 4'b0100); end
    @(negedge clk);
    ib.req_valid = 4'b0000;
    #1;
    checks++; if (ib.rsp_valid !== 1'b1) begin errors++; $display("FAIL ar_inflight got %b exp %b", ib.rsp_valid, 1'b1); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (ib.rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_async_valid got %b exp %b", ib.rsp_valid, 1'b0); end
    checks++; if (ib.rsp_dout !== 11'h000) begin errors++; $display("FAIL ar_async_dout got %h exp %h", ib.rsp_dout, 11'h000); end
    checks++; if (ib.busy !== 1'b0) begin errors++; $display("FAIL ar_async_busy got %b exp %b", ib.busy, 1'b0); end
    @(negedge clk);
    rst = 1'b0;
    set_ops_b(1, 7, 2);
    set_ops_b(3, 9, 9);
    ib.req_valid = 4'b1010;
    #1;
    // Before reset ptr was 3; a cleared ptr picks req1 over req3.
    checks++; if (ib.req_ready !== 4'b0010) begin errors++; $display("FAIL ar_post_ready got %b exp %b", ib.req_ready, 4'b0010); end
    checks++; if (ib.rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_stale0 got %b exp %b", ib.rsp_valid, 1'b0); end
    @(negedge clk);
    ib.req_valid = 4'b0000;
    #1;
    checks++; if (ib.rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_stale1 got %b exp %b", ib.rsp_valid, 1'b0); end
    @(negedge clk);
    #1;
    checks++; if (ib.rsp_valid !== 1'b1) begin errors++; $display("FAIL ar_new_valid got %b exp %b", ib.rsp_valid, 1'b1); end
    checks++; if (ib.rsp_id !== 2'd1) begin errors++; $display("FAIL ar_new_id got %0d exp %0d", ib.rsp_id, 2'd1); end
    checks++; if (ib.rsp_dout !== 11'd14) begin errors++; $display("FAIL ar_new_dout got %0d exp %0d", ib.rsp_dout, 11'd14); end
    @(negedge clk);
    #1;
    checks++; if (ib.rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_once got %b exp %b", ib.rsp_valid, 1'b0); end
  endtask

  initial begin
    ia.req_valid = 4'b0000;
    ia.req_din0  = '0;
    ia.req_din1  = '0;
    ia.rsp_ready = 1'b1;
    ib.req_valid = 4'b0000;
    ib.req_din0  = '0;
    ib.req_din1  = '0;
    ib.rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_truncation();
    test_pointer_wrap();
    test_contention();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_mul_share_arb.md
Name: sample_mul_share_arb

Overview:
- Round-robin arbiter and pipeline sequencer that time-shares one signed DATA_WIDTH x DATA_WIDTH multiplier among NUM_REQ requesters.
- The product is truncated to DATA_WIDTH bits, matching the existing sample_mul multiplier units.
- Sits between HLS-generated compute loops and the shared multiplier. It replaces per-loop multiplier instances in the resource-optimized build.
- Each accepted operand pair returns a single tagged result on a valid/ready response port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 11, operand and result width, signed
MUL_LATENCY, 1, pipeline stages from accept to result (1..4)
ID_WIDTH, 2, requester tag width; must be >= clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_din0  in  NUM_REQ*DATA_WIDTH  packed operand A; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_din1  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_id  out  ID_WIDTH  index of requester that produced the result
rsp_dout  out  DATA_WIDTH  truncated signed product
busy  out  1  any stage valid or any req_valid high

Behaviour:
- One clock domain (ap_clk). ap_rst is asynchronous and active-high.
- Reset values:
  - all pipeline valid bits 0, so rsp_valid=0;
  - rsp_id=0, rsp_dout=0;
  - round-robin pointer ptr=0;
  - req_ready=0 while ap_rst is high.
- Pipeline: MUL_LATENCY stages. Each stage holds {valid, id, data}. The last stage drives rsp_valid, rsp_id and rsp_dout.
- Advance: advance = !rsp_valid || rsp_ready.
  - When advance=1, all stages shift by one.
  - When advance=0, all stages hold, including bubbles. This is a global stall.
- Arbitration (combinational):
  - grant = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[i] = advance && grant==i && !ap_rst.
- Accept: occurs when req_valid[i] && req_ready[i]. On accept:
  - stage 0 loads valid=1, id=i, data = low DATA_WIDTH bits of $signed(din0_i) * $signed(din1_i). The full 2*DATA_WIDTH product is formed and then truncated; no saturation.
  - ptr <= (i+1) mod NUM_REQ.
- No accept: stage 0 loads valid=0 when advance=1. ptr holds.
- Latency: a result accepted at rising edge k has rsp_valid=1 after edge k+MUL_LATENCY-1, i.e. MUL_LATENCY cycles of pipeline, provided there is no stall.
- Throughput: one accept per cycle when rsp_ready is held high.
- Simultaneous response consume and new accept in the same cycle is permitted. There must be no bubble insertion.
- rsp_id and rsp_dout are stable while rsp_valid=1 and rsp_ready=0.
- Requester obligations: hold req_valid and operands until ready. A requester dropping valid before ready is tolerated: no state changes, and ptr does not move.
- Wrap-around: a grant to NUM_REQ-1 sets ptr=0.
- Reset mid-operation: all in-flight results are discarded immediately. No stale result appears after ap_rst deasserts. The first accept is possible on the first edge after deassertion.
- Requesters with index >= NUM_REQ do not exist. Tag bits above clog2(NUM_REQ) are 0.

Test Plan:
- Basic result, MUL_LATENCY=1, rsp_ready=1: req0 din0=5, din1=-3 -> req_ready[0]=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_dout=11'h7F1 (-15).
- Truncation: req2 din0=40, din1=40 -> rsp_dout=11'h640 (-448 signed), rsp_id=2.
- Full contention: all four req_valid held high, rsp_ready=1 -> accepts in order 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same order; one result per cycle.
- Pointer and wrap: ptr=2, only req0 and req3 valid -> req3 granted first (ptr becomes 0), then req0.
- Backpressure, MUL_LATENCY=2, continuous requests: drop rsp_ready for 3 cycles while rsp_valid=1 -> req_ready=0 throughout and rsp_dout/rsp_id stable. After rsp_ready returns, every accepted pair is delivered exactly once, in order.
- Async reset: assert ap_rst mid-cycle with 2 results in flight -> rsp_valid=0 without waiting for a clock edge, ptr=0. After release, no stale response; a new req1 request (7*2) returns 14 with rsp_id=1.
